// File: rtl/sensor_request_scheduler.sv
// Sensor request scheduler: queues UART-decoded requests in a 4-deep FIFO,
// paces sensor link accesses by a minimum interval, supervises each access
// with a timeout, and supports streaming commands terminated by a stop command.
module sensor_request_scheduler #(
  parameter int unsigned MIN_INTERVAL = 100000000,
  parameter int unsigned TIMEOUT      = 150000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [7:0] req_command,
  input  logic [7:0] req_address,
  output logic       req_ready,
  output logic       link_enable,
  output logic [7:0] link_command,
  output logic [7:0] link_address,
  input  logic       link_done,
  input  logic [7:0] link_resp_command,
  input  logic [7:0] link_resp_value,
  output logic       tx_valid,
  output logic [7:0] tx_command,
  output logic [7:0] tx_value,
  input  logic       tx_ready,
  output logic       busy
);

  localparam logic [7:0] CmdStreamA  = 8'h03;
  localparam logic [7:0] CmdStreamB  = 8'h04;
  localparam logic [7:0] CmdStopA    = 8'h05;
  localparam logic [7:0] CmdStopB    = 8'h06;
  localparam logic [7:0] RespBypass  = 8'hEF;
  localparam logic [7:0] RespTimeout = 8'hEE;
  localparam logic [7:0] RespNoStop  = 8'hFF;

  typedef enum logic [2:0] {StIdle, StGap, StIssue, StWait, StStream, StResp} state_e;

  state_e      state_q;
  logic [7:0]  fifo_cmd_q  [4];
  logic [7:0]  fifo_addr_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        push, pop, fifo_empty;
  logic [7:0]  head_cmd, head_addr;
  logic        done_q, done_edge, captured_edge;
  logic [31:0] interval_q, interval_d;
  logic        interval_ok;
  logic [31:0] timeout_q;
  logic        timeout_hit;
  logic        stream_cmd, head_stop, stop_driven;

  assign req_ready   = count_q != 3'd4;
  assign fifo_empty  = count_q == 3'd0;
  assign push        = req_valid && req_ready;
  assign head_cmd    = fifo_cmd_q[rd_ptr_q];
  assign head_addr   = fifo_addr_q[rd_ptr_q];
  assign busy        = state_q != StIdle;

  assign done_edge     = link_done && !done_q;
  assign captured_edge = done_edge && (state_q == StWait || state_q == StStream);
  // Counters compare their next value so the limit lands on the clock it is reached
  assign interval_ok   = interval_d == MIN_INTERVAL;
  assign timeout_hit   = (timeout_q + 32'd1) == TIMEOUT;

  assign stream_cmd  = link_command == CmdStreamA || link_command == CmdStreamB;
  assign head_stop   = head_cmd == CmdStopA || head_cmd == CmdStopB;
  assign stop_driven = link_command == CmdStopA || link_command == CmdStopB;

  // FIFO storage, written on push only
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_cmd_q[wr_ptr_q]  <= req_command;
      fifo_addr_q[wr_ptr_q] <= req_address;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      if (push && !pop)      count_q <= count_q + 3'd1;
      else if (pop && !push) count_q <= count_q - 3'd1;
    end
  end

  // Interval counter next value: cleared by a captured response, saturating
  always_comb begin
    if (captured_edge)                  interval_d = 32'd0;
    else if (interval_q >= MIN_INTERVAL) interval_d = MIN_INTERVAL;
    else                                interval_d = interval_q + 32'd1;
  end

  // link_done edge sampler and interval counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      interval_q <= MIN_INTERVAL;
    end else begin
      done_q     <= link_done;
      interval_q <= interval_d;
    end
  end

  // FIFO pop decision, mirroring the FSM transitions that consume the head
  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:   pop = !fifo_empty && head_addr != 8'h00;
      StWait:   pop = done_edge || timeout_hit;
      StStream: begin
        if (!fifo_empty) pop = head_stop ? (done_edge && stop_driven) : !tx_valid;
      end
      default:  pop = 1'b0;
    endcase
  end

  // Control FSM with registered link and transmit outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      link_enable  <= 1'b0;
      link_command <= 8'h00;
      link_address <= 8'h00;
      tx_valid     <= 1'b0;
      tx_command   <= 8'h00;
      tx_value     <= 8'h00;
      timeout_q    <= 32'd0;
    end else begin
      case (state_q)
        StIdle, StGap: begin
          if (!fifo_empty) begin
            if (head_addr != 8'h00) begin
              // Non-zero addresses are not served by the link; reject locally
              tx_valid   <= 1'b1;
              tx_command <= RespBypass;
              tx_value   <= RespBypass;
              state_q    <= StResp;
            end else if (interval_ok) begin
              link_enable  <= 1'b1;
              link_command <= head_cmd;
              link_address <= head_addr;
              timeout_q    <= 32'd0;
              state_q      <= StIssue;
            end else begin
              state_q <= StGap;
            end
          end
        end
        StIssue: begin
          timeout_q <= timeout_q + 32'd1;
          state_q   <= StWait;
        end
        StWait: begin
          if (done_edge) begin
            tx_valid   <= 1'b1;
            tx_command <= link_resp_command;
            tx_value   <= link_resp_value;
            if (stream_cmd) begin
              state_q <= StStream;
            end else begin
              link_enable  <= 1'b0;
              link_command <= 8'h00;
              link_address <= 8'h00;
              state_q      <= StResp;
            end
          end else if (timeout_hit) begin
            link_enable  <= 1'b0;
            link_command <= 8'h00;
            link_address <= 8'h00;
            tx_valid     <= 1'b1;
            tx_command   <= RespTimeout;
            tx_value     <= RespTimeout;
            state_q      <= StResp;
          end else begin
            timeout_q <= timeout_q + 32'd1;
          end
        end
        StStream: begin
          if (tx_valid && tx_ready) tx_valid <= 1'b0;
          if (!fifo_empty && head_stop) begin
            if (done_edge && stop_driven) begin
              // Final response supersedes any unsent stream sample
              tx_valid     <= 1'b1;
              tx_command   <= link_resp_command;
              tx_value     <= link_resp_value;
              link_enable  <= 1'b0;
              link_command <= 8'h00;
              link_address <= 8'h00;
              state_q      <= StResp;
            end else begin
              link_command <= head_cmd;
              link_address <= head_addr;
              if (done_edge && !tx_valid) begin
                tx_valid   <= 1'b1;
                tx_command <= link_resp_command;
                tx_value   <= link_resp_value;
              end
            end
          end else if (!fifo_empty) begin
            // Commands other than stop are refused while streaming
            if (!tx_valid) begin
              tx_valid   <= 1'b1;
              tx_command <= RespNoStop;
              tx_value   <= RespNoStop;
            end
          end else if (done_edge && !tx_valid) begin
            tx_valid   <= 1'b1;
            tx_command <= link_resp_command;
            tx_value   <= link_resp_value;
          end
        end
        StResp: begin
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
